// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
//
// Shared constants and types for the 4x3 keypad scanner.
//   NUM_ROWS / NUM_COLS : matrix geometry
//   KEY_STAR / KEY_HASH : codes reported for the '*' and '#' keys
//   kp_state_e          : debounce FSM state (RELEASED / PRESSED)
//   scan_cls_e          : classification of one complete scan
//   key_code_of()       : row/column position -> key code
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } kp_state_e;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_cls_e;

    // Rows 0..2 carry the digits 1..9 in reading order; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// -----------------------------------------------------------------------------
// keypad_tick_gen
//
// Free-running divider: raises tick_o for one clk cycle every SCAN_DIV cycles.
// The first tick appears SCAN_DIV cycles after reset is released.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   tick_o : one-cycle scan tick
// -----------------------------------------------------------------------------
module keypad_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int              CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb assigns each of its outputs on every path, so no latch is inferred.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Row-scanning, debouncing controller for a 4x3 key matrix. Each accepted key
// press is delivered once over a valid/ack handshake.
//
// Ports:
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   in_key[2:0] : column lines E,F,G (active-low)
//   out_singal  : row drives A..D (active-low, one-hot low)
//   key_valid   : event pending for the consumer
//   key_code    : code of the pending event, stable while key_valid
//   key_ack     : consumer accepts the pending event
//   key_held    : a debounced key is currently down
//   key_ovf     : one-cycle pulse, an event was dropped (previous one unacked)
//
// Build option:
//   KEYPAD_REPEAT_EN : when defined, a held key generates auto-repeat events
//                      after REPEAT_DELAY scans and then every REPEAT_RATE scans.
// -----------------------------------------------------------------------------
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 125,
    parameter int REPEAT_RATE    = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] in_key,
    output logic [3:0] out_singal,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ack,
    output logic       key_held,
    output logic       key_ovf
);

    localparam logic [3:0] DEB_CNT  = 4'(DEBOUNCE_SCANS);
    localparam logic [1:0] LAST_ROW = 2'(NUM_ROWS - 1);

    // ---------------------------------------------------------------- tick
    logic tick;

    keypad_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    // ---------------------------------------------------------------- state
    logic [2:0] key_sync1_q, key_sync2_q;
    logic [1:0] row_q;
    logic [1:0] acc_cnt_q, acc_cnt_d;
    logic [3:0] acc_code_q, acc_code_d;
    scan_cls_e  prev_cls_q, prev_cls_d;
    logic [3:0] prev_code_q, prev_code_d;
    kp_state_e  state_q, state_d;
    logic [3:0] stab_q, stab_d;
    logic [3:0] held_code_q, held_code_d;
    logic       valid_q, valid_d;
    logic [3:0] code_q, code_d;
    logic       ovf_q, ovf_d;

    // ---------------------------------------------------------------- scan
    logic [2:0] row_low;
    logic [1:0] row_cnt;
    logic [3:0] row_code;
    logic [2:0] sum_cnt;
    logic [1:0] tot_cnt;
    logic [3:0] tot_code;
    logic       scan_done;
    scan_cls_e  scan_cls;

    assign row_low = ~key_sync2_q;

    // Accumulate key count (saturating at 2) and the code of the first key
    // seen; the scan is classified on the tick that samples the last row.
    always_comb begin
        row_code = 4'd0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (row_low[c]) begin
                row_code = key_code_of(row_q, 2'(c));
            end
        end
        row_cnt   = 2'(row_low[0]) + 2'(row_low[1]) + 2'(row_low[2]);
        sum_cnt   = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
        tot_cnt   = (sum_cnt > 3'd2) ? 2'd2 : sum_cnt[1:0];
        tot_code  = (acc_cnt_q == 2'd0) ? row_code : acc_code_q;
        scan_done = tick && (row_q == LAST_ROW);
        case (tot_cnt)
            2'd0:    scan_cls = SCAN_NONE;
            2'd1:    scan_cls = SCAN_SINGLE;
            default: scan_cls = SCAN_MULTI;
        endcase
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (tick) begin
            acc_cnt_d  = scan_done ? 2'd0 : tot_cnt;
            acc_code_d = scan_done ? 4'd0 : tot_code;
        end
    end

    // ---------------------------------------------------------------- debounce
    logic       same_as_prev;
    logic       ev;
    logic [3:0] ev_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_next;
    logic             rep_first_q, rep_first_d;
    logic             rep_hit;

    assign rep_next = rep_cnt_q + REP_W'(1);
    assign rep_hit  = rep_first_q ? (rep_next == REP_W'(REPEAT_DELAY))
                                  : (rep_next == REP_W'(REPEAT_RATE));
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
`endif

    always_comb begin
        state_d      = state_q;
        stab_d       = stab_q;
        held_code_d  = held_code_q;
        prev_cls_d   = prev_cls_q;
        prev_code_d  = prev_code_q;
        same_as_prev = 1'b0;
        ev           = 1'b0;
        ev_code      = held_code_q;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d    = rep_cnt_q;
        rep_first_d  = rep_first_q;
`endif
        if (scan_done) begin
            prev_cls_d   = scan_cls;
            prev_code_d  = tot_code;
            same_as_prev = (scan_cls == prev_cls_q) &&
                           ((scan_cls != SCAN_SINGLE) || (tot_code == prev_code_q));
            case (state_q)
                ST_RELEASED: begin
                    // A fresh SINGLE counts as the first agreeing scan.
                    if (scan_cls == SCAN_SINGLE) begin
                        stab_d = same_as_prev ? stab_q + 4'd1 : 4'd1;
                    end else begin
                        stab_d = 4'd0;
                    end
                    if (stab_d == DEB_CNT) begin
                        ev          = 1'b1;
                        ev_code     = tot_code;
                        held_code_d = tot_code;
                        state_d     = ST_PRESSED;
                        stab_d      = 4'd0;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b1;
`endif
                    end
                end
                ST_PRESSED: begin
                    if (scan_cls == SCAN_NONE) begin
                        stab_d = same_as_prev ? stab_q + 4'd1 : 4'd1;
                    end else begin
                        stab_d = 4'd0;
                    end
                    if (stab_d == DEB_CNT) begin
                        state_d = ST_RELEASED;
                        stab_d  = 4'd0;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b1;
                    end else if ((scan_cls == SCAN_SINGLE) && (tot_code == held_code_q)) begin
                        if (rep_hit) begin
                            ev          = 1'b1;
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b0;
                        end else begin
                            rep_cnt_d = rep_next;
                        end
`endif
                    end
                end
                default: state_d = ST_RELEASED;
            endcase
        end
    end

    // ---------------------------------------------------------------- handshake
    // An ack in the same cycle frees the register, so a coincident event loads.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovf_d   = 1'b0;
        if (ev) begin
            if (!valid_q || key_ack) begin
                valid_d = 1'b1;
                code_d  = ev_code;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (key_ack) begin
            valid_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sync1_q <= 3'b111;
            key_sync2_q <= 3'b111;
            row_q       <= 2'd0;
            acc_cnt_q   <= 2'd0;
            acc_code_q  <= 4'd0;
            prev_cls_q  <= SCAN_NONE;
            prev_code_q <= 4'd0;
            state_q     <= ST_RELEASED;
            stab_q      <= 4'd0;
            held_code_q <= 4'd0;
            valid_q     <= 1'b0;
            code_q      <= 4'd0;
            ovf_q       <= 1'b0;
        end else begin
            // Column lines are asynchronous to clk; two flops before use.
            key_sync1_q <= in_key;
            key_sync2_q <= key_sync1_q;
            if (tick) begin
                row_q <= row_q + 2'd1;
            end
            acc_cnt_q   <= acc_cnt_d;
            acc_code_q  <= acc_code_d;
            prev_cls_q  <= prev_cls_d;
            prev_code_q <= prev_code_d;
            state_q     <= state_d;
            stab_q      <= stab_d;
            held_code_q <= held_code_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    // ---------------------------------------------------------------- outputs
    assign out_singal = ~(4'b0001 << row_q);
    assign key_valid  = valid_q;
    assign key_code   = code_q;
    assign key_held   = (state_q == ST_PRESSED);
    assign key_ovf    = ovf_q;

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan sequencer for the 4-row × 3-column key matrix.
- Drives the row lines one at a time and samples the column lines.
- Debounces across full scans and hands each accepted key to the consumer over a valid/ack handshake. The consumer is the display/adder logic.
- Replaces free-running row scanning with a deterministic, debounced, single-event-per-press controller.

## Interface
- SCAN_DIV, 100000: clk cycles per scan tick (1 kHz at 100 MHz); legal range ≥2.
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press or release; legal range 1..15.
- REPEAT_DELAY, 125: full scans held before the first auto-repeat (used only with KEYPAD_REPEAT_EN).
- REPEAT_RATE, 25: full scans between subsequent repeats (used only with KEYPAD_REPEAT_EN).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_key  in  3  column lines (E,F,G); active-low, pulled up externally.
- out_singal  out  4  row drives (A,B,C,D); active-low, exactly one bit low at all times.
- key_valid  out  1  key event pending.
- key_code  out  4  code of the pending event; stable while key_valid.
- key_ack  in  1  consumer accepts the event.
- key_held  out  1  a debounced key is currently down.
- key_ovf  out  1  one-cycle pulse: an event was dropped because the previous one was unacknowledged.

## Operation
- Tick: an internal counter wraps every SCAN_DIV cycles and produces a one-cycle tick.
- Row sequencing: row index r cycles 0→1→2→3→0; out_singal = ~(1<<r).
- At each tick, in_key is sampled for the current row and then r advances, so each row gets one full tick period of settle time.
- A full scan is 4 ticks. It ends on the tick that samples row 3.
- Scan result classes:
  - NONE: no column low.
  - SINGLE(code): exactly one key low in the whole scan.
  - MULTI: more than one key low. MULTI resets the stability counter and is otherwise ignored.
- Key code map, row/col → code:
  - r0: 1,2,3
  - r1: 4,5,6
  - r2: 7,8,9
  - r3: 14 (*), 0, 15 (#)
- Debounce FSM:
  - RELEASED: a SINGLE(c) result matching the previous scan result increments the stability counter; any other result reloads it. When the count reaches DEBOUNCE_SCANS, emit an event with code c, set key_held, and go to PRESSED.
  - PRESSED: NONE results count the same way; DEBOUNCE_SCANS consecutive NONE results clear key_held and go to RELEASED. A different SINGLE while PRESSED is ignored, with no event, until release.
- Handshake:
  - key_valid is set on an event and cleared on the first cycle key_ack=1. key_code is loaded only when an event is accepted into the output register.
  - If an event arrives while key_valid=1 and key_ack=0, the event is dropped, key_ovf pulses, and key_code is unchanged.
  - If an event arrives in the same cycle as key_ack=1, the new event is loaded and key_valid stays 1.
  - key_ack while key_valid=0 has no effect.
- Reset (asynchronous, any time, including mid-scan):
  - Outputs: out_singal=4'b1110, key_valid=0, key_code=0, key_held=0, key_ovf=0.
  - Internal: tick counter, stability counter and repeat counter = 0; FSM = RELEASED.

## Timing
- Press latency: key_valid rises 1 cycle after the tick that completes the DEBOUNCE_SCANS-th agreeing scan.
- Minimum latency from a stable press is DEBOUNCE_SCANS×4 ticks, plus up to 4 ticks of scan alignment.
- Release latency for key_held falling is the same structure.
- key_ovf is high for exactly 1 cycle.
- Outputs are registered; there are no combinational paths from in_key or key_ack to outputs.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, a repeat counter counts full scans with the key still SINGLE(c).
  - The first extra event is emitted at REPEAT_DELAY scans, then one every REPEAT_RATE scans.
  - Repeat events obey the same handshake and overflow rules.
  - The counter clears on release.
- KEYPAD_REPEAT_EN undefined: exactly one event per debounced press, REPEAT_* are ignored, and no repeat logic is synthesized.

## Structure
- Package keypad_pkg holds:
  - NUM_ROWS=4, NUM_COLS=3
  - code constants KEY_STAR=14, KEY_HASH=15
  - the row/col→code mapping function
  - FSM state typedef (RELEASED, PRESSED)
- Sub-module keypad_tick_gen: SCAN_DIV divider producing the one-cycle tick. Everything else stays in keypad_scan_ctrl.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2 for simulation.
- Reset release with no keys → out_singal walks 1110, 1101, 1011, 0111, one step per 4 clk; key_valid stays 0.
- Key r1/c2 held for 3 scans with ack tied high → exactly one key_valid pulse with key_code=6; key_held=1; key_held falls 2 scans after release.
- Bounce: r0/c0 present in alternate scans only → no event.
- Two keys pressed simultaneously (codes 1 and 5) → MULTI, no event, key_held stays 0.
- Press 7, never ack, then release and press 9 → key_code stays 7, key_ovf pulses once at the 9 event; when a later ack coincides with a new 0 event, key_code=0 and key_valid remains 1.
- KEYPAD_REPEAT_EN with REPEAT_DELAY=3, REPEAT_RATE=2, # held 10 scans, ack high → events at scans 2, 5, 7, 9 (4 events, code 15). Assert rst_n mid-hold → all outputs at reset values immediately.
